// File: rtl/cpu_ctrl_if.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_if
// Bundles the two buses that leave the CPU controller:
//   - instruction-memory fetch handshake (imem_req/imem_addr -> imem_ack/imem_data)
//   - ALU drive (opcode, immediates, register operands, load enable) and the
//     ALU status/result signals that come back.
// Modports:
//   master : the controller (drives fetch requests and ALU operands)
//   slave  : instruction memory + ALU (answers fetches, returns results)
// ----------------------------------------------------------------------------
interface cpu_ctrl_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUS_WIDTH    = 8,
    parameter int OPCODE_WIDTH = 6,
    parameter int NREGS        = 8,
    parameter int PC_WIDTH     = 8,
    parameter int INSTR_WIDTH  = OPCODE_WIDTH + $clog2(NREGS) + 2 * BUS_WIDTH
);
    // instruction fetch
    logic                    imem_req;
    logic [PC_WIDTH-1:0]     imem_addr;
    logic                    imem_ack;
    logic [INSTR_WIDTH-1:0]  imem_data;

    // ALU drive
    logic                    alu_en;
    logic [OPCODE_WIDTH-1:0] alu_opcode;
    logic [BUS_WIDTH-1:0]    alu_addr1;
    logic [BUS_WIDTH-1:0]    alu_addr2;
    logic [DATA_WIDTH-1:0]   alu_value1;
    logic [DATA_WIDTH-1:0]   alu_value2;

    // ALU return
    logic [DATA_WIDTH-1:0]   alu_result;
    logic                    alu_calc_done;
    logic                    alu_err;
    logic                    alu_finish;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output alu_en, alu_opcode, alu_addr1, alu_addr2, alu_value1, alu_value2,
        input  alu_result, alu_calc_done, alu_err, alu_finish
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  alu_en, alu_opcode, alu_addr1, alu_addr2, alu_value1, alu_value2,
        output alu_result, alu_calc_done, alu_err, alu_finish
    );
endinterface

// File: rtl/cpu_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_ctrl
// Instruction sequencer + register file driving an external ALU.
// Fetches an instruction word, decodes it into opcode/dst/addr1/addr2,
// presents register operands and immediates to the ALU, strobes alu_en until
// the ALU reports completion and writes the ALU's registered result back to
// regs[dst]. Stops on the all-ones finish opcode or on an ALU error.
//
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   run        : leave SIDLE and start fetching at pc
//   bus        : cpu_ctrl_if.master (fetch handshake + ALU operand/result bus)
//   pc         : program counter
//   busy       : executing (any state except SIDLE/SHALT)
//   halted     : terminal SHALT state reached
//   err_flag   : sticky ALU error
//   dbg_sel    : debug register select
//   dbg_data   : regs[dbg_sel], combinational
// ----------------------------------------------------------------------------
module cpu_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUS_WIDTH    = 8,
    parameter int OPCODE_WIDTH = 6,
    parameter int NREGS        = 8,
    parameter int PC_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     run,
    cpu_ctrl_if.master               bus,
    output logic [PC_WIDTH-1:0]      pc,
    output logic                     busy,
    output logic                     halted,
    output logic                     err_flag,
    input  logic [$clog2(NREGS)-1:0] dbg_sel,
    output logic [DATA_WIDTH-1:0]    dbg_data
);
    localparam int IDX_W       = $clog2(NREGS);
    localparam int INSTR_WIDTH = OPCODE_WIDTH + IDX_W + 2 * BUS_WIDTH;

    // Instruction field boundaries: {opcode, dst, addr1, addr2}, MSB first.
    localparam int A2_LSB  = 0;
    localparam int A1_LSB  = BUS_WIDTH;
    localparam int DST_LSB = 2 * BUS_WIDTH;
    localparam int OP_LSB  = 2 * BUS_WIDTH + IDX_W;

    localparam logic [2:0] SIDLE  = 3'd0;
    localparam logic [2:0] SFETCH = 3'd1;
    localparam logic [2:0] SREAD  = 3'd2;
    localparam logic [2:0] SCALC  = 3'd3;
    localparam logic [2:0] SWRITE = 3'd4;
    localparam logic [2:0] SHALT  = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   err_q, err_d;
    logic                   reg_we;
    logic [DATA_WIDTH-1:0]  regs_q [NREGS];

    // Decoded fields of the held instruction.
    logic [OPCODE_WIDTH-1:0] op_f;
    logic [IDX_W-1:0]        dst_idx;
    logic [BUS_WIDTH-1:0]    a1_f;
    logic [BUS_WIDTH-1:0]    a2_f;

    assign op_f    = ir_q[OP_LSB  +: OPCODE_WIDTH];
    assign dst_idx = ir_q[DST_LSB +: IDX_W];
    assign a1_f    = ir_q[A1_LSB  +: BUS_WIDTH];
    assign a2_f    = ir_q[A2_LSB  +: BUS_WIDTH];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        err_d   = err_q;
        reg_we  = 1'b0;

        case (state_q)
            SIDLE: begin
                if (run) state_d = SFETCH;
            end
            SFETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_data;
                    state_d = SREAD;
                end
            end
            SREAD: begin
                // Finish opcode stops here, before the ALU is ever enabled.
                state_d = bus.alu_finish ? SHALT : SCALC;
            end
            SCALC: begin
                if (bus.alu_calc_done) begin
                    if (bus.alu_err) begin
                        err_d   = 1'b1;
                        state_d = SHALT;
                    end else begin
                        state_d = SWRITE;
                    end
                end
            end
            SWRITE: begin
                // alu_result was loaded on the last SCALC edge, so it already
                // reflects the old operands even when dst is also a source.
                reg_we  = 1'b1;
                pc_d    = pc_q + PC_WIDTH'(1);
                state_d = SFETCH;
            end
            SHALT: begin
                state_d = SHALT;
            end
            default: begin
                state_d = SIDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            state_q <= SIDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

    // Register file: a handful of flops read combinationally by the ALU
    // operand muxes and the debug port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: this array is plain flops, not a RAM macro, and software
            // relies on it reading zero after reset, so it is reset here.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[dst_idx] <= bus.alu_result;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.imem_req   = (state_q == SFETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.alu_en     = (state_q == SCALC);
    assign bus.alu_opcode = op_f;
    assign bus.alu_addr1  = a1_f;
    assign bus.alu_addr2  = a2_f;
    // Register operands are always offered; the ALU picks immediate or
    // register per operand from the opcode.
    assign bus.alu_value1 = regs_q[a1_f[IDX_W-1:0]];
    assign bus.alu_value2 = regs_q[a2_f[IDX_W-1:0]];

    assign pc       = pc_q;
    assign busy     = (state_q == SFETCH) || (state_q == SREAD) ||
                      (state_q == SCALC)  || (state_q == SWRITE);
    assign halted   = (state_q == SHALT);
    assign err_flag = err_q;
    assign dbg_data = regs_q[dbg_sel];
endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
Instruction sequencer and register file that drives the ALU: the initiator side of the ALU operand/opcode/result interface. Fetches instruction words over a req/ack instruction-memory handshake and decodes them into opcode plus operand fields. Presents register values and immediates to the ALU, strobes the ALU enable, and writes the registered result back to the destination register. Sits between instruction memory and the ALU; stops on the all-ones finish opcode or an ALU error.

Parameters:
DATA_WIDTH, 8, register and ALU data width
BUS_WIDTH, 8, width of each addr/immediate field sent to the ALU
OPCODE_WIDTH, 6, ALU opcode width
NREGS, 8, number of general registers; index = low log2(NREGS) bits of a field
PC_WIDTH, 8, program counter / imem address width
INSTR_WIDTH, OPCODE_WIDTH+log2(NREGS)+2*BUS_WIDTH (25 at defaults), instruction word width

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
run  in  1  start execution from SIDLE
imem_req  out  1  fetch request
imem_addr  out  PC_WIDTH  fetch address (= pc)
imem_ack  in  1  fetch data valid
imem_data  in  INSTR_WIDTH  instruction word
alu_en  out  1  ALU result-register load enable
alu_opcode  out  OPCODE_WIDTH  ALU opcode
alu_addr1, alu_addr2  out  BUS_WIDTH  ALU immediates (instruction fields)
alu_value1, alu_value2  out  DATA_WIDTH  register operands
alu_result  in  DATA_WIDTH  registered ALU result
alu_calc_done  in  1  ALU operation complete
alu_err  in  1  ALU error
alu_finish  in  1  ALU reports finish opcode
pc  out  PC_WIDTH  program counter
busy  out  1  high in every state except SIDLE/SHALT
halted  out  1  high in SHALT
err_flag  out  1  sticky ALU error
dbg_sel  in  log2(NREGS)  debug register select
dbg_data  out  DATA_WIDTH  regs[dbg_sel], combinational

Behaviour:
- Reset (async, rstn=0): state=SIDLE; pc, ir, all regs, err_flag = 0. All outputs 0 except dbg_data (= regs[dbg_sel] = 0). Reset mid-operation aborts immediately; nothing is written back.
- Instruction fields: ir[24:19]=opcode, ir[18:16]=dst, ir[15:8]=addr1, ir[7:0]=addr2 (defaults).
- ALU drive, all states: alu_opcode=ir opcode field, alu_addr1/2=ir fields, alu_value1=regs[addr1 idx], alu_value2=regs[addr2 idx]. Immediate vs register selection is done by the ALU via opcode[0]/[1].
- SIDLE: imem_req=0. run=1 -> SFETCH.
- SFETCH: imem_req=1, imem_addr=pc, held stable until imem_ack. imem_ack sampled the same cycle; on ack, ir<=imem_data, -> SREAD. No timeout.
- SREAD: one cycle for operand setup. alu_finish=1 -> SHALT with no alu_en; else -> SCALC.
- SCALC: alu_en=1 every cycle in this state. Waits while alu_calc_done=0.
  - alu_calc_done=1 and alu_err=1 -> err_flag<=1, -> SHALT, no writeback.
  - alu_calc_done=1 and alu_err=0 -> SWRITE.
- SWRITE: alu_en=0. regs[dst]<=alu_result (the ALU loaded it on the last SCALC edge). pc<=pc+1, wrapping modulo 2^PC_WIDTH. -> SFETCH.
- SHALT: terminal until rstn. run is ignored. halted=1.
- dst may equal a source index. Operands are consumed before SWRITE, so the write uses the already-latched result.
- Throughput: 4 cycles per instruction with same-cycle ack and calc_done. Each ack-wait or calc_done-wait cycle adds 1.
- busy=1 in SFETCH, SREAD, SCALC, SWRITE.

Test Plan:
- Program LI r1,5 (0b000011_001_00000101_00000000); LI r2,3; ADD r3,r1,r2 (opcode 000000, addr1=1, addr2=2); HALT (opcode 111111). imem acks same cycle, ALU model attached. -> regs r1=5, r2=3, r3=8; halted=1 at cycle 14 after run; pc=3; err_flag=0.
- imem_ack delayed 3 cycles on second fetch -> imem_req=1 and imem_addr=1 stable all 3 cycles; no alu_en; r2 still written 3 cycles later than in the first test.
- Force alu_err=1 with calc_done on ADD to r3 (r3=0x55 beforehand) -> SHALT next cycle, err_flag=1, r3 stays 0x55, pc unchanged.
- r1=0x90; ADD r1,r1,r1 -> r1=0x20 (mod 256); next fetch at pc+1.
- Preload pc=255 via a 255-NOP program (non-finish opcode, e.g. XOR r0,r0) -> after that instruction's SWRITE, imem_addr=0.
- Assert rstn=0 during SCALC with alu_calc_done held 0 -> all outputs 0, regs cleared, SIDLE. run=1 restarts fetch at pc=0.
